// File: rtl/sample_frame_builder.sv
// sample_frame_builder: turns L1A words and ADC samples pulled by the
// transfer FSM into a CRC-protected 16-bit DAQ frame for the link FIFO.
module sample_frame_builder #(
  parameter int          RD_LAT   = 2,
  parameter int          NWORDS   = 96,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        L1A_RD_EN,
  input  logic        RDENA,
  input  logic [11:0] L1A_DATA,
  input  logic [11:0] ADC_DATA,
  input  logic        AFULL,
  output logic [15:0] DOUT,
  output logic        DOUT_VLD,
  output logic        SOF,
  output logic        EOF,
  output logic        FRAME_ERR,
  output logic [7:0]  DROP_CNT,
  output logic [1:0]  FSTATE
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  localparam logic [6:0] NW  = 7'(NWORDS);
  localparam logic [6:0] NW1 = 7'(NWORDS - 1);

  state_t state, state_n;

  logic [RD_LAT-1:0] l1a_sr, adc_sr;
  logic              l1a_vld, adc_vld;

  logic [15:0] crc, crc_n;
  logic [6:0]  cnt, cnt_n;
  logic        drop_l1a, dl1a_n;
  logic [7:0]  dcnt_n;
  logic [15:0] dout_n;
  logic        vld_n, sof_n, eof_n, err_n;

  assign l1a_vld = l1a_sr[RD_LAT-1];
  assign adc_vld = adc_sr[RD_LAT-1];
  assign FSTATE  = state;

  // CRC-CCITT, one 16-bit word per call, MSB first
  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [15:0] d
  );
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // delay read strobes so they line up with buffer output data
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      l1a_sr <= '0;
      adc_sr <= '0;
    end else begin
      l1a_sr[0] <= L1A_RD_EN;
      adc_sr[0] <= RDENA;
      for (int i = 1; i < RD_LAT; i++) begin
        l1a_sr[i] <= l1a_sr[i-1];
        adc_sr[i] <= adc_sr[i-1];
      end
    end
  end

  // state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (l1a_vld) state_n = AFULL ? DROP : HDR;
      HDR:  if (l1a_vld) state_n = DATA;
      DATA: begin
        if (cnt == NW)    state_n = IDLE;
        else if (l1a_vld) state_n = HDR;
      end
      DROP: begin
        if (l1a_vld && drop_l1a)        state_n = IDLE;
        else if (adc_vld && cnt == NW1) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // output and datapath next values
  always_comb begin
    dout_n = '0;
    vld_n  = 1'b0;
    sof_n  = 1'b0;
    eof_n  = 1'b0;
    err_n  = 1'b0;
    crc_n  = crc;
    cnt_n  = cnt;
    dcnt_n = DROP_CNT;
    dl1a_n = drop_l1a;
    unique case (state)
      IDLE: begin
        if (adc_vld) err_n = 1'b1;
        if (l1a_vld && AFULL) begin
          if (DROP_CNT != 8'hFF) dcnt_n = DROP_CNT + 8'd1;
          cnt_n  = '0;
          dl1a_n = 1'b0;
        end else if (l1a_vld) begin
          dout_n = {4'hA, L1A_DATA};
          vld_n  = 1'b1;
          sof_n  = 1'b1;
          crc_n  = crc_upd(CRC_INIT, {4'hA, L1A_DATA});
        end
      end
      HDR: begin
        if (adc_vld) err_n = 1'b1;
        if (l1a_vld) begin
          dout_n = {4'hB, L1A_DATA};
          vld_n  = 1'b1;
          crc_n  = crc_upd(crc, {4'hB, L1A_DATA});
          cnt_n  = '0;
        end
      end
      DATA: begin
        if (cnt == NW) begin
          // trailer slot; the CRC restarts so a following frame is independent
          dout_n = crc;
          vld_n  = 1'b1;
          eof_n  = 1'b1;
          crc_n  = CRC_INIT;
          cnt_n  = '0;
          if (adc_vld || l1a_vld) err_n = 1'b1;
        end else if (l1a_vld) begin
          // short frame: poisoned trailer, resumed frame starts a fresh CRC
          dout_n = ~crc;
          vld_n  = 1'b1;
          eof_n  = 1'b1;
          err_n  = 1'b1;
          crc_n  = CRC_INIT;
          cnt_n  = '0;
        end else if (adc_vld) begin
          dout_n = {4'h0, ADC_DATA};
          vld_n  = 1'b1;
          crc_n  = crc_upd(crc, {4'h0, ADC_DATA});
          cnt_n  = cnt + 7'd1;
        end
      end
      DROP: begin
        if (l1a_vld && drop_l1a) begin
          err_n = 1'b1;
          cnt_n = '0;
        end else begin
          if (l1a_vld) dl1a_n = 1'b1;
          if (adc_vld) cnt_n = (cnt == NW1) ? 7'd0 : cnt + 7'd1;
        end
      end
      default: ;
    endcase
  end

  // registered outputs and datapath state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DOUT      <= '0;
      DOUT_VLD  <= 1'b0;
      SOF       <= 1'b0;
      EOF       <= 1'b0;
      FRAME_ERR <= 1'b0;
      DROP_CNT  <= '0;
      crc       <= CRC_INIT;
      cnt       <= '0;
      drop_l1a  <= 1'b0;
    end else begin
      DOUT      <= dout_n;
      DOUT_VLD  <= vld_n;
      SOF       <= sof_n;
      EOF       <= eof_n;
      FRAME_ERR <= err_n;
      DROP_CNT  <= dcnt_n;
      crc       <= crc_n;
      cnt       <= cnt_n;
      drop_l1a  <= dl1a_n;
    end
  end

endmodule

// File: tb/tb_sample_frame_builder.sv
// tb_sample_frame_builder: directed scenarios for the DAQ frame builder,
// with a 2-cycle buffer model in front of the data inputs.
module tb_sample_frame_builder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        L1A_RD_EN = 1'b0;
  logic        RDENA = 1'b0;
  logic [11:0] L1A_DATA;
  logic [11:0] ADC_DATA;
  logic        AFULL = 1'b0;
  logic [15:0] DOUT;
  logic        DOUT_VLD, SOF, EOF, FRAME_ERR;
  logic [7:0]  DROP_CNT;
  logic [1:0]  FSTATE;

  sample_frame_builder dut (
    .CLK(CLK), .RST(RST),
    .L1A_RD_EN(L1A_RD_EN), .RDENA(RDENA),
    .L1A_DATA(L1A_DATA), .ADC_DATA(ADC_DATA),
    .AFULL(AFULL), .DOUT(DOUT), .DOUT_VLD(DOUT_VLD),
    .SOF(SOF), .EOF(EOF), .FRAME_ERR(FRAME_ERR),
    .DROP_CNT(DROP_CNT), .FSTATE(FSTATE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] d;
    logic        sof;
    logic        eof;
    logic        err;
    int          cyc;
  } wd_t;

  wd_t q[$];
  wd_t e[$];
  int  cyc = 0;
  int  errs = 0;
  int  total = 0;
  int  bad = 0;

  logic [11:0] l1a_val = '0, adc_val = '0;
  logic [11:0] l1a_p1 = '0, l1a_p2 = '0;
  logic [11:0] adc_p1 = '0, adc_p2 = '0;

  assign L1A_DATA = l1a_p2;
  assign ADC_DATA = adc_p2;

  // buffers present read data two cycles after the strobe
  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    l1a_p1 <= l1a_val;
    l1a_p2 <= l1a_p1;
    adc_p1 <= adc_val;
    adc_p2 <= adc_p1;
  end

  // record every written word and every error pulse
  always @(negedge CLK) begin
    if (DOUT_VLD === 1'b1)
      q.push_back(wd_t'{DOUT, SOF, EOF, FRAME_ERR, cyc});
    if (FRAME_ERR === 1'b1) errs++;
  end

  function automatic logic [15:0] ref_crc(
    input logic [15:0] c0,
    input logic [15:0] w
  );
    logic [15:0] c;
    c = c0;
    for (int b = 15; b >= 0; b--) begin
      if (c[15] ^ w[b]) c = (c << 1) ^ 16'h1021;
      else              c = c << 1;
    end
    return c;
  endfunction

  // append one expected frame; with_a=0 starts at the B word
  task automatic mk_frame(input bit with_a, input bit short_end,
                          input logic [11:0] a0, input logic [11:0] a1,
                          input int base, input int n);
    logic [15:0] c, w;
    c = 16'hFFFF;
    if (with_a) begin
      w = {4'hA, a0};
      e.push_back(wd_t'{w, 1'b1, 1'b0, 1'b0, 0});
      c = ref_crc(c, w);
    end
    w = {4'hB, a1};
    e.push_back(wd_t'{w, 1'b0, 1'b0, 1'b0, 0});
    c = ref_crc(c, w);
    for (int i = 0; i < n; i++) begin
      w = {4'h0, 12'(base + i)};
      e.push_back(wd_t'{w, 1'b0, 1'b0, 1'b0, 0});
      c = ref_crc(c, w);
    end
    if (short_end) e.push_back(wd_t'{~c, 1'b0, 1'b1, 1'b1, 0});
    else           e.push_back(wd_t'{c, 1'b0, 1'b1, 1'b0, 0});
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_event(input logic [11:0] a0, input logic [11:0] a1,
                            input int base, input int n, input int gap);
    L1A_RD_EN = 1'b1; l1a_val = a0; tick();
    l1a_val = a1; tick();
    L1A_RD_EN = 1'b0;
    for (int i = 0; i < n; i++) begin
      RDENA = 1'b1; adc_val = 12'(base + i); tick();
    end
    RDENA = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) tick();
    total++;
    if ({DOUT, DOUT_VLD, SOF, EOF, FRAME_ERR} !== 20'h0) begin
      bad++;
      $display("FAIL rst_out got=%h/%b%b%b%b exp=0", DOUT, DOUT_VLD,
               SOF, EOF, FRAME_ERR);
    end
    total++;
    if (DROP_CNT !== 8'd0 || FSTATE !== 2'd0) begin
      bad++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0", DROP_CNT, FSTATE);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    int start;
    q.delete(); e.delete(); errs = 0;
    mk_frame(1, 0, 12'h123, 12'h456, 0, 96);
    start = cyc;
    send_event(12'h123, 12'h456, 0, 96, 8);
    total++;
    if (q.size() !== e.size()) begin
      bad++;
      $display("FAIL nom_len got=%0d exp=%0d", q.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < q.size(); i++) begin
      total++;
      if (q[i].d !== e[i].d || q[i].sof !== e[i].sof ||
          q[i].eof !== e[i].eof || q[i].err !== e[i].err) begin
        bad++;
        $display("FAIL nom_w%0d got=%h/%b%b%b exp=%h/%b%b%b", i,
                 q[i].d, q[i].sof, q[i].eof, q[i].err,
                 e[i].d, e[i].sof, e[i].eof, e[i].err);
      end
    end
    if (q.size() > 0) begin
      total++;
      if (q[0].cyc - start !== 3) begin
        bad++;
        $display("FAIL nom_lat got=%0d exp=3", q[0].cyc - start);
      end
    end
    total++;
    if (errs !== 0 || FSTATE !== 2'd0) begin
      bad++;
      $display("FAIL nom_end got=%0d/%0d exp=0/0", errs, FSTATE);
    end
  endtask

  task automatic test_back_to_back();
    q.delete(); e.delete(); errs = 0;
    mk_frame(1, 0, 12'h321, 12'h654, 100, 96);
    mk_frame(1, 0, 12'hFED, 12'h0BA, 7, 96);
    send_event(12'h321, 12'h654, 100, 96, 5);
    send_event(12'hFED, 12'h0BA, 7, 96, 8);
    total++;
    if (q.size() !== e.size()) begin
      bad++;
      $display("FAIL b2b_len got=%0d exp=%0d", q.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < q.size(); i++) begin
      total++;
      if (q[i].d !== e[i].d || q[i].sof !== e[i].sof ||
          q[i].eof !== e[i].eof || q[i].err !== e[i].err) begin
        bad++;
        $display("FAIL b2b_w%0d got=%h/%b%b%b exp=%h/%b%b%b", i,
                 q[i].d, q[i].sof, q[i].eof, q[i].err,
                 e[i].d, e[i].sof, e[i].eof, e[i].err);
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL b2b_err got=%0d exp=0", errs);
    end
  endtask

  task automatic test_short();
    q.delete(); e.delete(); errs = 0;
    mk_frame(1, 1, 12'h111, 12'h222, 0, 50);
    mk_frame(0, 0, 12'h000, 12'h444, 20, 96);
    send_event(12'h111, 12'h222, 0, 50, 0);
    send_event(12'h333, 12'h444, 20, 96, 8);
    total++;
    if (q.size() !== e.size()) begin
      bad++;
      $display("FAIL short_len got=%0d exp=%0d", q.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < q.size(); i++) begin
      total++;
      if (q[i].d !== e[i].d || q[i].sof !== e[i].sof ||
          q[i].eof !== e[i].eof || q[i].err !== e[i].err) begin
        bad++;
        $display("FAIL short_w%0d got=%h/%b%b%b exp=%h/%b%b%b", i,
                 q[i].d, q[i].sof, q[i].eof, q[i].err,
                 e[i].d, e[i].sof, e[i].eof, e[i].err);
      end
    end
    total++;
    if (errs !== 1) begin
      bad++;
      $display("FAIL short_err got=%0d exp=1", errs);
    end
  endtask

  task automatic test_drop();
    q.delete(); errs = 0;
    AFULL = 1'b1;
    send_event(12'h0AA, 12'h0BB, 0, 96, 8);
    total++;
    if (DROP_CNT !== 8'd1 || FSTATE !== 2'd0) begin
      bad++;
      $display("FAIL drop_one got=%0d/%0d exp=1/0", DROP_CNT, FSTATE);
    end
    for (int k = 1; k < 300; k++) send_event(12'h0AA, 12'h0BB, 0, 96, 8);
    total++;
    if (DROP_CNT !== 8'd255) begin
      bad++;
      $display("FAIL drop_sat got=%0d exp=255", DROP_CNT);
    end
    send_event(12'h0CC, 12'h0DD, 0, 10, 0);
    L1A_RD_EN = 1'b1; tick();
    L1A_RD_EN = 1'b0;
    repeat (8) tick();
    AFULL = 1'b0;
    total++;
    if (errs !== 1 || FSTATE !== 2'd0 || DROP_CNT !== 8'd255) begin
      bad++;
      $display("FAIL drop_l1a3 got=%0d/%0d/%0d exp=1/0/255",
               errs, FSTATE, DROP_CNT);
    end
    total++;
    if (q.size() !== 0) begin
      bad++;
      $display("FAIL drop_vld got=%0d exp=0", q.size());
    end
  endtask

  task automatic test_stray();
    q.delete(); errs = 0;
    repeat (3) begin
      RDENA = 1'b1; tick();
      RDENA = 1'b0; tick();
    end
    repeat (4) tick();
    total++;
    if (errs !== 3) begin
      bad++;
      $display("FAIL stray_err got=%0d exp=3", errs);
    end
    total++;
    if (q.size() !== 0 || FSTATE !== 2'd0) begin
      bad++;
      $display("FAIL stray_vld got=%0d/%0d exp=0/0", q.size(), FSTATE);
    end
  endtask

  task automatic test_reset_mid();
    bit eof_seen;
    q.delete(); e.delete(); errs = 0;
    send_event(12'h0AB, 12'h0CD, 0, 40, 3);
    total++;
    if (q.size() !== 42 || FSTATE !== 2'd2) begin
      bad++;
      $display("FAIL mid_pre got=%0d/%0d exp=42/2", q.size(), FSTATE);
    end
    RST = 1'b1;
    #1;
    total++;
    if ({DOUT, DOUT_VLD, SOF, EOF, FRAME_ERR} !== 20'h0 ||
        DROP_CNT !== 8'd0 || FSTATE !== 2'd0) begin
      bad++;
      $display("FAIL mid_rst got=%h/%b/%0d/%0d exp=0", DOUT, DOUT_VLD,
               DROP_CNT, FSTATE);
    end
    repeat (2) tick();
    RST = 1'b0;
    tick();
    eof_seen = 1'b0;
    foreach (q[i]) if (q[i].eof) eof_seen = 1'b1;
    total++;
    if (eof_seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_eof got=1 exp=0");
    end
    q.delete(); errs = 0;
    mk_frame(1, 0, 12'h5A5, 12'hA5A, 3, 96);
    send_event(12'h5A5, 12'hA5A, 3, 96, 8);
    total++;
    if (q.size() !== e.size()) begin
      bad++;
      $display("FAIL mid_len got=%0d exp=%0d", q.size(), e.size());
    end
    for (int i = 0; i < e.size() && i < q.size(); i++) begin
      total++;
      if (q[i].d !== e[i].d || q[i].sof !== e[i].sof ||
          q[i].eof !== e[i].eof || q[i].err !== e[i].err) begin
        bad++;
        $display("FAIL mid_w%0d got=%h/%b%b%b exp=%h/%b%b%b", i,
                 q[i].d, q[i].sof, q[i].eof, q[i].err,
                 e[i].d, e[i].sof, e[i].eof, e[i].err);
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL mid_err got=%0d exp=0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_short();
    test_stray();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
